fetch_unit: RTL and testbench

- IF stage plus IF/ID pipeline register for the delayed-branch MIPS pipeline.
- Owns the fetch PC and issues single-outstanding requests to instruction memory.
- Holds the fetched instruction for the decode stage.
- Applies next-PC redirects from the ID-stage `PCsrc` (pfu_op), with exactly one delay slot.
- Honours the decode-stage `pause_out` stall.

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/pfu_target_calc.sv | 40 ++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the IF stage: PCsrc codes, reset PC, FSM states, IF/ID record.
package fetch_unit_pkg;

    localparam int unsigned PFU_OP_LENGTH = 3;

    localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_NEXT      = 3'd0;
    localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_OFFSET_16 = 3'd1;
    localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_OFFSET_26 = 3'd2;
    localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_JUMP      = 3'd3;
    localparam logic [PFU_OP_LENGTH-1:0] PFU_OP_RS        = 3'd4;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        FsIdle,
        FsFetch,
        FsHold
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus8;
    } ifid_t;

    // Codes 5-7 are reserved and behave as NEXT.
    function automatic logic is_redirect_op(input logic [PFU_OP_LENGTH-1:0] op);
        return (op >= PFU_OP_OFFSET_16) && (op <= PFU_OP_RS);
    endfunction

endpackage

// File: rtl/pfu_target_calc.sv
// Combinational next-PC target for the branch/jump currently held in IF/ID.
module pfu_target_calc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PFU_OP_W = PFU_OP_LENGTH
) (
    input  logic [31:0]         id_pc,
    input  logic [31:0]         id_instr,
    input  logic [31:0]         rs_data,
    input  logic [PFU_OP_W-1:0] pfu_op,
    output logic [31:0]         target,
    output logic                misalign
);

    logic [31:0] pc4;
    logic [31:0] off16;
    logic [31:0] off26;
    logic        unused_instr;

    assign pc4          = id_pc + 32'd4;
    assign off16        = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign off26        = {{4{id_instr[25]}}, id_instr[25:0], 2'b00};
    assign unused_instr = ^id_instr[31:26];

    always_comb begin
        target = pc4;
        case (pfu_op)
            PFU_OP_NEXT:      target = pc4;
            PFU_OP_OFFSET_16: target = pc4 + off16;
            PFU_OP_OFFSET_26: target = pc4 + off26;
            PFU_OP_JUMP:      target = {pc4[31:28], id_instr[25:0], 2'b00};
            // Low bits forced to zero; a misaligned RS is caught separately when enabled.
            PFU_OP_RS:        target = {rs_data[31:2], 2'b00};
            default:          target = pc4;
        endcase
    end

    assign misalign = (pfu_op == PFU_OP_RS) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: single-outstanding fetch, one-delay-slot redirect, decode stall.
// Build option PFU_ALIGN_CHECK_EN: misaligned RS redirects are dropped and flagged on fetch_misalign.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned PFU_OP_W = PFU_OP_LENGTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic [PFU_OP_W-1:0] pfu_op,
    input  logic [31:0]         rs_data,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_rdata,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_pc_plus8,
    output logic                fetch_misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    ifid_t        ifid_q, ifid_d;

    logic [31:0]  target;
    logic [31:0]  npc;
    logic         misalign;
    logic         redirect_req;
    logic         redirect;
    logic         load_fetch;
    logic         load_hold;
    logic         load;

    pfu_target_calc #(
        .PFU_OP_W (PFU_OP_W)
    ) u_target_calc (
        .id_pc    (ifid_q.pc),
        .id_instr (ifid_q.instr),
        .rs_data  (rs_data),
        .pfu_op   (pfu_op),
        .target   (target),
        .misalign (misalign)
    );

    // The branch leaves ID only in a non-stalled cycle; a stalled branch is re-evaluated later.
    assign redirect_req = ifid_q.valid && !stall && is_redirect_op(pfu_op);

`ifdef PFU_ALIGN_CHECK_EN
    assign redirect       = redirect_req && !misalign;
    assign fetch_misalign = redirect_req && misalign;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
    assign redirect        = redirect_req;
    assign fetch_misalign  = 1'b0;
`endif

    assign load_fetch = (state_q == FsFetch) && imem_valid && !stall;
    assign load_hold  = (state_q == FsHold) && !stall;
    assign load       = load_fetch || load_hold;

    // The delay slot is at pc_f, so npc only matters when that slot is being loaded.
    assign npc = redirect     ? target    :
                 pend_valid_q ? pend_pc_q : pc_f_q + 32'd4;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FsIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FsIdle:  state_d = FsFetch;
            FsFetch: if (imem_valid && stall) state_d = FsHold;
            FsHold:  if (!stall) state_d = FsFetch;
            default: state_d = FsIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem_req  = (state_q == FsFetch);
        imem_addr = pc_f_q;
    end

    always_comb begin
        pc_f_d       = pc_f_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        hold_instr_d = hold_instr_q;
        ifid_d       = ifid_q;

        if (load) begin
            ifid_d.valid    = 1'b1;
            ifid_d.instr    = load_fetch ? imem_rdata : hold_instr_q;
            ifid_d.pc       = pc_f_q;
            ifid_d.pc_plus8 = pc_f_q + 32'd8;
            pc_f_d          = npc;
            pend_valid_d    = 1'b0;
        end else begin
            if ((state_q == FsFetch) && !stall) begin
                ifid_d.valid = 1'b0;
                ifid_d.instr = NOP_INSTR;
            end
            // Delay slot still in flight: remember where to go once it lands.
            if (redirect) begin
                pend_pc_d    = target;
                pend_valid_d = 1'b1;
            end
        end

        if ((state_q == FsFetch) && imem_valid && stall) begin
            hold_instr_d = imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q       <= RESET_PC;
            pend_pc_q    <= 32'h0;
            pend_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            ifid_q       <= '0;
        end else begin
            pc_f_q       <= pc_f_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            hold_instr_q <= hold_instr_d;
            ifid_q       <= ifid_d;
        end
    end

    assign id_valid    = ifid_q.valid;
    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_pc_plus8 = ifid_q.pc_plus8;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scenario table drives a memory/decoder model; scoreboard checks fetch and decode order.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pfu_op = 3'd0;
    logic [31:0] rs_data = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus8;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .pfu_op         (pfu_op),
        .rs_data        (rs_data),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus8    (id_pc_plus8),
        .fetch_misalign (fetch_misalign)
    );

    // pre_tgt != 0 puts a jr to pre_tgt at RST_PC; br_pc holds the branch under test.
    typedef struct {
        string       name;
        logic [31:0] pre_tgt;
        logic [31:0] br_pc;
        logic [31:0] instr;
        logic [2:0]  op;
        logic [31:0] rs;
        logic        taken;
        logic [31:0] tgt;
        int          lat;
        int          stall_at;
        int          n;
        int          mis;
    } scen_t;

    scen_t       tbl[10];
    scen_t       cur;
    scen_t       rst_rec;
    int          passed = 0;
    int          total = 0;
    logic [31:0] ret_q[$];
    logic [31:0] fet_q[$];
    bit          mon_en = 1'b0;
    bit          inj = 1'b0;
    int          mis_cnt = 0;
    int          mem_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == cur.br_pc) return cur.instr;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: response in the lat-th cycle of a request; stray pulse injectable in reset.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_cnt    = 0;
            imem_valid = inj;
            imem_rdata = 32'hDEAD_BEEF;
        end else begin
            if (imem_valid) begin
                imem_valid = 1'b0;
                mem_cnt    = 0;
            end
            if (imem_req) begin
                mem_cnt++;
                if (mem_cnt >= cur.lat) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end
            end
        end
    end

    // Decode-stage model: branch ops for known PCs; junk ops while ID holds a bubble.
    always @(posedge clk) begin
        #1;
        if (id_valid && cur.pre_tgt != 32'h0 && id_pc == RST_PC) begin
            pfu_op  = 3'd4;
            rs_data = cur.pre_tgt;
        end else if (id_valid && id_pc == cur.br_pc) begin
            pfu_op  = cur.op;
            rs_data = cur.rs;
        end else if (id_valid) begin
            pfu_op  = 3'd0;
            rs_data = $urandom;
        end else begin
            pfu_op  = 3'($urandom_range(1, 4));
            rs_data = $urandom;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en && rst_n) begin
            if (fetch_misalign) mis_cnt++;
            if (imem_req && imem_valid && fet_q.size() > 0) begin
                e = fet_q.pop_front();
                check({cur.name, ":imem_addr"}, imem_addr, e);
            end
            if (id_valid && !stall && ret_q.size() > 0) begin
                e = ret_q.pop_front();
                check({cur.name, ":id_pc"}, id_pc, e);
                check({cur.name, ":id_instr"}, id_instr, mem_word(e));
                check({cur.name, ":id_pc_plus8"}, id_pc_plus8, e + 32'd8);
            end
        end
    end

    task automatic run(input scen_t s);
        logic [31:0] pc;
        logic [31:0] nxt;
        logic [31:0] ptgt;
        bit          pend;
        int          cyc;
        int          first;
        @(negedge clk);
        rst_n  = 1'b0;
        stall  = 1'b0;
        mon_en = 1'b0;
        cur    = s;
        ret_q.delete();
        fet_q.delete();
        mis_cnt = 0;
        pc   = RST_PC;
        pend = 1'b0;
        ptgt = 32'h0;
        // Architectural order with one delay slot per taken branch.
        for (int i = 0; i < s.n + 6; i++) begin
            if (i < s.n) ret_q.push_back(pc);
            fet_q.push_back(pc);
            nxt  = pend ? ptgt : pc + 32'd4;
            pend = 1'b0;
            if (s.pre_tgt != 32'h0 && pc == RST_PC) begin
                pend = 1'b1;
                ptgt = s.pre_tgt;
            end else if (s.taken && pc == s.br_pc) begin
                pend = 1'b1;
                ptgt = s.tgt;
            end
            pc = nxt;
        end
        @(posedge clk);
        #1;
        check({s.name, ":rst_imem_req"}, 32'(imem_req), 32'h0);
        check({s.name, ":rst_imem_addr"}, imem_addr, RST_PC);
        check({s.name, ":rst_id_valid"}, 32'(id_valid), 32'h0);
        check({s.name, ":rst_id_instr"}, id_instr, 32'h0);
        check({s.name, ":rst_id_pc"}, id_pc, 32'h0);
        check({s.name, ":rst_id_pc_plus8"}, id_pc_plus8, 32'h0);
        check({s.name, ":rst_misalign"}, 32'(fetch_misalign), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        first  = 0;
        cyc    = 0;
        while (ret_q.size() > 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            inj = 1'b0;
            cyc++;
            stall = (s.stall_at != 0 && cyc >= s.stall_at && cyc < s.stall_at + 4);
            if (first == 0 && id_valid) begin
                first = cyc;
                check({s.name, ":first_valid_clock"}, 32'(cyc), 32'(s.lat + 1));
            end
            if (s.stall_at != 0 && cyc > s.stall_at && cyc < s.stall_at + 4)
                check({s.name, ":hold_req"}, 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        check({s.name, ":undelivered"}, 32'(ret_q.size()), 32'h0);
        @(negedge clk);
        check({s.name, ":misalign_pulses"}, 32'(mis_cnt), 32'(s.mis));
        mon_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           name     pre_tgt       br_pc         instr         op    rs            tk tgt          lat stl n  mis
        tbl[0] = '{"seq",      32'h0,        32'hFFFF_0000, 32'h0,        3'd0, 32'h0,        0, 32'h0,        1, 0, 6,  0};
        tbl[1] = '{"beq_fwd",  32'h0,        32'h0000_3010, 32'h1000_0004, 3'd1, 32'h0,        1, 32'h0000_3024, 1, 0, 8,  0};
        tbl[2] = '{"jr_lat3",  32'h0,        32'h0000_3014, 32'h0080_0008, 3'd4, 32'h0000_4000, 1, 32'h0000_4000, 3, 0, 8,  0};
        tbl[3] = '{"stall_br", 32'h0,        32'h0000_3010, 32'h1000_0004, 3'd1, 32'h0,        1, 32'h0000_3024, 1, 6, 9,  0};
        tbl[4] = '{"j_region", 32'h3000_0000, 32'h3000_0000, 32'h0800_0100, 3'd3, 32'h0,        1, 32'h3000_0400, 1, 0, 7,  0};
        tbl[5] = '{"op6_next", 32'h0,        32'h0000_3008, 32'h1000_0010, 3'd6, 32'h0,        0, 32'h0,        2, 0, 7,  0};
        tbl[6] = '{"bne_back", 32'h0,        32'h0000_3010, 32'h1400_FFFC, 3'd1, 32'h0,        1, 32'h0000_3004, 2, 0, 12, 0};
        tbl[7] = '{"off26_neg", 32'h0,       32'h0000_3008, 32'h0BFF_FFF0, 3'd2, 32'h0,        1, 32'h0000_2FCC, 1, 0, 7,  0};
`ifdef PFU_ALIGN_CHECK_EN
        tbl[8] = '{"jr_misal", 32'h0,        32'h0000_3008, 32'h0080_0008, 3'd4, 32'h0000_4002, 0, 32'h0,        1, 0, 7,  1};
`else
        tbl[8] = '{"jr_misal", 32'h0,        32'h0000_3008, 32'h0080_0008, 3'd4, 32'h0000_4002, 1, 32'h0000_4000, 1, 0, 7,  0};
`endif
        tbl[9] = '{"pc_wrap",  32'hFFFF_FFF8, 32'hFFFF_0000, 32'h0,        3'd0, 32'h0,        0, 32'h0,        2, 0, 7,  0};
        rst_rec = '{"rst_restart", 32'h0,    32'hFFFF_0000, 32'h0,        3'd0, 32'h0,        0, 32'h0,        2, 0, 5,  0};

        for (int i = 0; i < 10; i++) run(tbl[i]);

        // Reset while a latency-3 request is outstanding, with a stray response across release.
        cur = tbl[2];
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_req", 32'(imem_req), 32'h1);
        inj = 1'b1;
        run(rst_rec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
